// File: rtl/stb_pkg.sv
// rtl/stb_pkg.sv - shared types and constants for the store-buffer AXI write engine
package stb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR   = 2'd2
  } stb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned PAGE_BYTES    = 4096;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stb_wdata_fifo.sv
// rtl/stb_wdata_fifo.sv - synchronous W-data FIFO with occupancy count
module stb_wdata_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stb_axi_wr_engine.sv
// rtl/stb_axi_wr_engine.sv - store micro-instructions to native AXI INCR write bursts
module stb_axi_wr_engine
  import stb_pkg::*;
#(
  parameter int UR_ADDR_WIDTH = 11,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int BYTE_STRB     = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 4,
  parameter int MAX_OUTSTD    = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_micro_inst_u_valid,
  output logic                     o_micro_inst_u_ready,
  input  logic [3:0]               i_micro_inst_u_len,
  input  logic [BYTE_STRB-1:0]     i_micro_inst_u_byte_strb,
  input  logic [ADDR_WIDTH-1:0]    i_micro_inst_u_gr_base_addr,
  input  logic [UR_ADDR_WIDTH-1:0] i_micro_inst_u_ur_addr,
  input  logic [ID_WIDTH-1:0]      i_micro_inst_u_id,
  output logic                     o_micro_inst_d_done,
  output logic [ID_WIDTH-1:0]      o_micro_inst_d_id,
  output logic                     o_micro_inst_d_err,
  output logic                     o_ur_re,
  output logic [UR_ADDR_WIDTH-1:0] o_ur_addr,
  input  logic [DATA_WIDTH-1:0]    i_ur_rdata,
  output logic [ID_WIDTH-1:0]      awid,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic [3:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [BYTE_STRB-1:0]     wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [ID_WIDTH-1:0]      bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [1:0]               o_state
);
  localparam int          SIZE_LOG2 = clog2(BYTE_STRB);
  localparam int          CW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  MAX_O     = 4'(MAX_OUTSTD);
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(FIFO_DEPTH);

  stb_state_t state, state_nxt;

  logic                     run_q;
  logic [3:0]               len_q;
  logic [BYTE_STRB-1:0]     strb_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [UR_ADDR_WIDTH-1:0] ur_addr_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [4:0]               rd_cnt, w_cnt;
  logic                     rd_inflight, aw_done, w_done;
  logic [3:0]               outstd;
  logic                     done_q, err_q;
  logic [ID_WIDTH-1:0]      done_id_q;

  logic                     fifo_full, fifo_empty;
  logic [CW:0]              fifo_count;
  logic [DATA_WIDTH-1:0]    fifo_head;

  logic        accept, bad_inst, misaligned, crosses;
  logic [12:0] page_end;
  logic        aw_hs, w_hs, b_fire, fifo_room;

  // run_q holds ready/bready/awsize low until the first clock after reset
  assign o_micro_inst_u_ready = run_q && (state == ST_IDLE) && (outstd < MAX_O);
  assign accept     = i_micro_inst_u_valid && o_micro_inst_u_ready;
  assign misaligned = |i_micro_inst_u_gr_base_addr[SIZE_LOG2-1:0];
  assign page_end   = {1'b0, i_micro_inst_u_gr_base_addr[11:0]}
                    + (({9'd0, i_micro_inst_u_len} + 13'd1) << SIZE_LOG2);
  assign crosses    = page_end > 13'(PAGE_BYTES);
  assign bad_inst   = misaligned || crosses;

  assign bready = run_q && (state != ST_ERR);
  assign b_fire = bvalid && bready && (outstd != 4'd0);

  assign fifo_room = !fifo_full &&
                     (({1'b0, fifo_count} + {{(CW+1){1'b0}}, rd_inflight}) < DEPTH_W);
  assign o_ur_re   = (state == ST_BURST) && (rd_cnt <= {1'b0, len_q}) && fifo_room;
  assign o_ur_addr = ur_addr_q + UR_ADDR_WIDTH'(rd_cnt);

  assign awvalid = (state == ST_BURST) && !aw_done;
  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = run_q ? 3'(SIZE_LOG2) : 3'd0;
  assign awburst = run_q ? AXI_BURST_INCR : 2'b00;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wvalid = (state == ST_BURST) && !fifo_empty;
  assign wdata  = wvalid ? fifo_head : '0;
  assign wstrb  = strb_q;
  assign wlast  = wvalid && (w_cnt == {1'b0, len_q});
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;

  assign o_micro_inst_d_done = done_q;
  assign o_micro_inst_d_err  = err_q;
  assign o_micro_inst_d_id   = done_id_q;
  assign o_state             = state;

  stb_wdata_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_inflight),
    .push_data (i_ur_rdata),
    .pop       (w_hs),
    .rd_data   (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = bad_inst ? ST_ERR : ST_BURST;
      ST_BURST: if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      len_q       <= '0;
      strb_q      <= '0;
      addr_q      <= '0;
      ur_addr_q   <= '0;
      id_q        <= '0;
      rd_cnt      <= '0;
      w_cnt       <= '0;
      rd_inflight <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      outstd      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      done_id_q   <= '0;
    end else begin
      run_q       <= 1'b1;
      rd_inflight <= o_ur_re;
      if (accept) begin
        len_q     <= i_micro_inst_u_len;
        strb_q    <= i_micro_inst_u_byte_strb;
        addr_q    <= i_micro_inst_u_gr_base_addr;
        ur_addr_q <= i_micro_inst_u_ur_addr;
        id_q      <= i_micro_inst_u_id;
        rd_cnt    <= '0;
        w_cnt     <= '0;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else begin
        if (o_ur_re)        rd_cnt  <= rd_cnt + 5'd1;
        if (w_hs)           w_cnt   <= w_cnt + 5'd1;
        if (aw_hs)          aw_done <= 1'b1;
        if (w_hs && wlast)  w_done  <= 1'b1;
      end
      case ({accept && !bad_inst, b_fire})
        2'b10:   outstd <= outstd + 4'd1;
        2'b01:   outstd <= outstd - 4'd1;
        default: outstd <= outstd;
      endcase
      // bready is low in ERR, so the error pulse and a B completion never share a cycle
      done_q    <= b_fire || (state == ST_ERR);
      err_q     <= (state == ST_ERR) || (b_fire && (bresp != AXI_RESP_OKAY));
      done_id_q <= (state == ST_ERR) ? id_q : (b_fire ? bid : '0);
    end
  end

endmodule

// File: tb/tb_stb_axi_wr_engine.sv
// tb/tb_stb_axi_wr_engine.sv - directed vector bench for stb_axi_wr_engine
`timescale 1ns/1ps
module tb_stb_axi_wr_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         u_valid = 1'b0, u_ready;
  logic [3:0]   u_len = '0;
  logic [15:0]  u_strb = '0;
  logic [31:0]  u_addr = '0;
  logic [10:0]  u_ur = '0;
  logic [3:0]   u_id = '0;
  logic         d_done, d_err;
  logic [3:0]   d_id;
  logic         ur_re;
  logic [10:0]  ur_addr;
  logic [127:0] ur_rdata = '0;
  logic [3:0]   awid, awlen, awcache;
  logic [31:0]  awaddr;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst;
  logic         awlock, awvalid, awready = 1'b0;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready = 1'b0;
  logic [3:0]   bid = '0;
  logic [1:0]   bresp = '0;
  logic         bvalid = 1'b0, bready;
  logic [1:0]   o_state;

  always #5 clk = ~clk;

  stb_axi_wr_engine dut (
    .clk(clk), .rst_n(rst_n),
    .i_micro_inst_u_valid(u_valid), .o_micro_inst_u_ready(u_ready),
    .i_micro_inst_u_len(u_len), .i_micro_inst_u_byte_strb(u_strb),
    .i_micro_inst_u_gr_base_addr(u_addr), .i_micro_inst_u_ur_addr(u_ur),
    .i_micro_inst_u_id(u_id),
    .o_micro_inst_d_done(d_done), .o_micro_inst_d_id(d_id), .o_micro_inst_d_err(d_err),
    .o_ur_re(ur_re), .o_ur_addr(ur_addr), .i_ur_rdata(ur_rdata),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .o_state(o_state)
  );

  typedef struct {
    logic [3:0]  len;
    logic [31:0] addr;
    logic [10:0] ur;
    logic [15:0] strb;
    logic [3:0]  id;
    logic [1:0]  bresp;
    logic        exp_err;
    logic        exp_aw;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int aw_delay = 0;
  int aw_seen = 0;
  logic w_toggle = 1'b0;

  function automatic logic [127:0] ur_pat(input logic [10:0] a);
    return {4{21'h1ABCD, a}};
  endfunction

  // UR file: data for the row requested on one edge is visible the whole next cycle
  always @(posedge clk) ur_rdata <= ur_re ? ur_pat(ur_addr) : '0;

  always @(posedge clk) begin
    #1;
    wready = w_toggle ? ~wready : 1'b1;
    if (awvalid) begin
      aw_seen++;
      awready = (aw_seen > aw_delay);
    end else begin
      aw_seen = 0;
      awready = 1'b0;
    end
  end

  logic [127:0] wd_q[$];
  logic         wl_q[$];
  logic [15:0]  ws_q[$];
  logic [10:0]  ur_q[$];
  logic [4:0]   dn_q[$];
  int           aw_cnt = 0, aw_viol = 0;
  logic         aw_pend = 1'b0;
  logic [31:0]  pend_addr, cap_awaddr;
  logic [3:0]   pend_len, cap_awlen, cap_awid;
  logic [2:0]   cap_awsize;
  logic [1:0]   cap_awburst;

  always @(negedge clk) begin
    if (ur_re) ur_q.push_back(ur_addr);
    if (wvalid && wready) begin
      wd_q.push_back(wdata); wl_q.push_back(wlast); ws_q.push_back(wstrb);
    end
    if (d_done) dn_q.push_back({d_err, d_id});
    if (aw_pend && (!awvalid || awaddr != pend_addr || awlen != pend_len)) aw_viol++;
    aw_pend = awvalid && !awready;
    pend_addr = awaddr;
    pend_len = awlen;
    if (awvalid && awready) begin
      aw_cnt++;
      cap_awaddr = awaddr; cap_awlen = awlen; cap_awid = awid;
      cap_awsize = awsize; cap_awburst = awburst;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wd_q.delete(); wl_q.delete(); ws_q.delete(); ur_q.delete(); dn_q.delete();
    aw_cnt = 0; aw_viol = 0; aw_pend = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue(input vec_t v, input int bound, output logic acc);
    @(posedge clk); #1;
    u_valid = 1'b1; u_len = v.len; u_addr = v.addr; u_ur = v.ur; u_strb = v.strb; u_id = v.id;
    acc = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (u_ready) begin acc = 1'b1; break; end
    end
    @(posedge clk); #1;
    u_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    @(posedge clk); #1;
    bvalid = 1'b1; bid = id; bresp = resp;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bready) break;
    end
    check("b_bready", bready, 1'b1);
    @(posedge clk); #1;
    bvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin tick(); n++; end while (o_state != 2'd0 && n < 200);
    check({name, "_idle"}, o_state, 2'd0);
  endtask

  task automatic wait_done(input string name, input int n_exp);
    int n = 0;
    while (dn_q.size() < n_exp && n < 40) begin tick(); n++; end
    tick(); tick();
    check({name, "_done_cnt"}, dn_q.size(), n_exp);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic acc;
    logic [10:0] a;
    int beats;
    clear_mon();
    issue(v, 50, acc);
    check({name, "_accept"}, acc, 1'b1);
    wait_idle(name);
    if (v.exp_aw) send_b(v.id, v.bresp);
    wait_done(name, 1);
    if (dn_q.size() > 0) begin
      check({name, "_done_id"}, dn_q[0][3:0], v.id);
      check({name, "_done_err"}, dn_q[0][4], v.exp_err);
    end
    beats = v.exp_aw ? int'(v.len) + 1 : 0;
    check({name, "_aw_cnt"}, aw_cnt, v.exp_aw ? 1 : 0);
    check({name, "_w_cnt"}, wd_q.size(), beats);
    check({name, "_ur_cnt"}, ur_q.size(), beats);
    check({name, "_aw_stable"}, aw_viol, 0);
    if (v.exp_aw && aw_cnt == 1) begin
      check({name, "_awaddr"}, cap_awaddr, v.addr);
      check({name, "_awlen"}, cap_awlen, v.len);
      check({name, "_awid"}, cap_awid, v.id);
      check({name, "_awsize"}, cap_awsize, 3'd4);
      check({name, "_awburst"}, cap_awburst, 2'b01);
    end
    for (int i = 0; i < wd_q.size() && i < beats; i++) begin
      a = v.ur + 11'(i);
      check($sformatf("%s_wdata%0d", name, i), wd_q[i], ur_pat(a));
      check($sformatf("%s_wlast%0d", name, i), wl_q[i], (i == beats - 1));
      check($sformatf("%s_wstrb%0d", name, i), ws_q[i], v.strb);
    end
    for (int i = 0; i < ur_q.size() && i < beats; i++) begin
      a = v.ur + 11'(i);
      check($sformatf("%s_uraddr%0d", name, i), ur_q[i], a);
    end
  endtask

  vec_t vecs[6];
  vec_t v, va, vb;
  logic acc;
  int n;

  initial begin
    vecs[0] = '{4'd0,  32'h0000_1000, 11'd5,    16'hFFFF, 4'd3,  2'b00, 1'b0, 1'b1};
    vecs[1] = '{4'd3,  32'h0000_2040, 11'd100,  16'h00FF, 4'd7,  2'b00, 1'b0, 1'b1};
    vecs[2] = '{4'd1,  32'h0000_0FF0, 11'd0,    16'hFFFF, 4'd9,  2'b00, 1'b1, 1'b0};
    vecs[3] = '{4'd0,  32'h0000_1004, 11'd0,    16'hFFFF, 4'd10, 2'b00, 1'b1, 1'b0};
    vecs[4] = '{4'd15, 32'h0000_0F00, 11'd2040, 16'hF0F0, 4'd1,  2'b11, 1'b1, 1'b1};
    vecs[5] = '{4'd7,  32'h0000_3000, 11'd12,   16'hFFFF, 4'd15, 2'b01, 1'b1, 1'b1};

    #2;
    check("rst_ready", u_ready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_done", d_done, 1'b0);
    check("rst_state", o_state, 2'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_bready", bready, 1'b1);
    check("post_rst_ready", u_ready, 1'b1);
    check("post_rst_awsize", awsize, 3'd4);
    check("post_rst_awburst", awburst, 2'b01);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // 16 beats with wready toggling and AW held off for 10 cycles
    w_toggle = 1'b1; aw_delay = 10;
    v = '{4'd15, 32'h0000_8000, 11'd300, 16'hFFFF, 4'd6, 2'b00, 1'b0, 1'b1};
    run_vec(v, "burst16");
    w_toggle = 1'b0; aw_delay = 0;

    // outstanding limit with B held off
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      v = '{4'd0, 32'h0000_4000 + 32'(i * 16), 11'(i), 16'hFFFF, 4'(i), 2'b00, 1'b0, 1'b1};
      issue(v, 50, acc);
      check($sformatf("outstd_acc%0d", i), acc, 1'b1);
    end
    v = '{4'd0, 32'h0000_4040, 11'd4, 16'hFFFF, 4'd4, 2'b00, 1'b0, 1'b1};
    issue(v, 20, acc);
    check("outstd_rej5", acc, 1'b0);
    tick();
    check("outstd_ready_low", u_ready, 1'b0);
    send_b(4'd0, 2'b00);
    tick();
    check("outstd_ready_back", u_ready, 1'b1);
    issue(v, 20, acc);
    check("outstd_acc5", acc, 1'b1);
    v = '{4'd0, 32'h0000_4050, 11'd5, 16'hFFFF, 4'd5, 2'b00, 1'b0, 1'b1};
    issue(v, 20, acc);
    check("outstd_rej6", acc, 1'b0);
    for (int i = 1; i < 5; i++) send_b(4'(i), 2'b00);
    wait_done("outstd", 5);
    for (int i = 0; i < dn_q.size() && i < 5; i++)
      check($sformatf("outstd_done%0d", i), dn_q[i], {1'b0, 4'(i)});
    check("outstd_aw_cnt", aw_cnt, 5);

    // stray B with nothing outstanding
    clear_mon();
    send_b(4'd7, 2'b00);
    tick(); tick(); tick();
    check("stray_b_no_done", dn_q.size(), 0);
    run_vec(vecs[1], "after_stray");

    // SLVERR on the second of two outstanding bursts
    clear_mon();
    va = '{4'd1, 32'h0000_5000, 11'd40, 16'hFFFF, 4'd4, 2'b00, 1'b0, 1'b1};
    vb = '{4'd2, 32'h0000_6000, 11'd50, 16'hFFFF, 4'd5, 2'b10, 1'b1, 1'b1};
    issue(va, 50, acc); check("slv_acc_a", acc, 1'b1);
    wait_idle("slv_a");
    issue(vb, 50, acc); check("slv_acc_b", acc, 1'b1);
    wait_idle("slv_b");
    send_b(4'd4, 2'b00);
    send_b(4'd5, 2'b10);
    wait_done("slv", 2);
    if (dn_q.size() >= 2) begin
      check("slv_done0", dn_q[0], 5'h04);
      check("slv_done1", dn_q[1], 5'h15);
    end

    // asynchronous reset while beat 7 of 16 is on the W channel
    clear_mon();
    aw_delay = 20;
    v = '{4'd15, 32'h0000_9000, 11'd600, 16'hFFFF, 4'd2, 2'b00, 1'b0, 1'b1};
    issue(v, 50, acc);
    check("mid_rst_acc", acc, 1'b1);
    n = 0;
    while (wd_q.size() < 7 && n < 200) begin tick(); n++; end
    check("mid_rst_reach_beat7", wd_q.size(), 7);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", awvalid, 1'b0);
    check("mid_rst_wvalid", wvalid, 1'b0);
    check("mid_rst_wlast", wlast, 1'b0);
    check("mid_rst_ur_re", ur_re, 1'b0);
    check("mid_rst_state", o_state, 2'd0);
    check("mid_rst_ready", u_ready, 1'b0);
    check("mid_rst_bready", bready, 1'b0);
    check("mid_rst_done", d_done, 1'b0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    aw_delay = 0;
    tick();
    check("post_mid_rst_state", o_state, 2'd0);
    run_vec(vecs[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/stb_axi_wr_engine.md
Name: stb_axi_wr_engine

Overview:
- Parametrised successor to the store-buffer top: converts store micro-instructions into native AXI write bursts.
- Drives AW/W/B directly, with no generic-interface master in between.
- Per instruction: reads 1..16 beats from the user register (UR) file, buffers them in a small data FIFO, issues one INCR burst, and reports completion per ID when the B response returns.
- Supports up to MAX_OUTSTD instructions awaiting B responses.

Parameters:
- UR_ADDR_WIDTH, 11: UR address width.
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 128: data width; a power of two, 32..1024.
- BYTE_STRB, DATA_WIDTH/8: byte lanes.
- ID_WIDTH, 4: AXI/instruction ID width.
- MAX_OUTSTD, 4: maximum instructions awaiting B (1..15).
- FIFO_DEPTH, 4: W-data FIFO entries; a power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- i_micro_inst_u_valid  in  1  instruction valid.
- o_micro_inst_u_ready  out  1  instruction accept.
- i_micro_inst_u_len  in  4  beats-1.
- i_micro_inst_u_byte_strb  in  BYTE_STRB  strobe applied to every beat.
- i_micro_inst_u_gr_base_addr  in  ADDR_WIDTH  AXI start address.
- i_micro_inst_u_ur_addr  in  UR_ADDR_WIDTH  first UR row.
- i_micro_inst_u_id  in  ID_WIDTH  tag, used as awid.
- o_micro_inst_d_done  out  1  one-cycle completion pulse.
- o_micro_inst_d_id  out  ID_WIDTH  completed tag.
- o_micro_inst_d_err  out  1  qualifies done: bresp!=OKAY, or a rejected instruction.
- o_ur_re  out  1  UR read enable.
- o_ur_addr  out  UR_ADDR_WIDTH  UR row.
- i_ur_rdata  in  DATA_WIDTH  valid exactly 1 cycle after o_ur_re.
- awid/awaddr/awlen(4)/awsize(3)/awburst(2)/awlock(1)/awcache(4)/awprot(3)/awvalid  out;  awready  in.
- wdata/wstrb/wlast/wvalid  out;  wready  in.
- bid(ID_WIDTH)/bresp(2)/bvalid  in;  bready  out.
- o_state  out  2  FSM state.

Behaviour:
Reset and interface rules:
- Reset is asynchronous, active-low: rst_n low clears everything at once, independent of clk.
- All outputs reset to 0: valids, done, err, ready, bready and o_state.
- Reset mid-burst: FIFO, counters and outstanding count are cleared and the in-flight AXI burst is abandoned (global reset).
- From the first clock after reset: bready=1 except in ERR; awburst=INCR(01); awsize=log2(BYTE_STRB); awlock/awcache/awprot=0.

FSM: IDLE(0), BURST(1), ERR(2).
- IDLE: o_micro_inst_u_ready = (outstd < MAX_OUTSTD). On valid&ready, latch the instruction fields.
  - Go to ERR if gr_base_addr is not BYTE_STRB-aligned, or if base[11:0] + (len+1)*BYTE_STRB > 4096.
  - Otherwise go to BURST and increment outstd.
- ERR: one cycle. Pulse done=1, err=1 with the latched ID. bready=0, so no B collision. Then return to IDLE. No AXI traffic is issued.
- BURST: AW and W progress independently.
  - awvalid is asserted on entry and held, with stable payload, until awready.
  - UR reads: one per cycle while rd_cnt<=len and fifo_cnt + rd_inflight < FIFO_DEPTH. o_ur_addr = ur_addr + rd_cnt, wrapping modulo 2^UR_ADDR_WIDTH.
  - Returned data is pushed into the FIFO the next cycle.
  - wvalid = FIFO not empty; wdata = FIFO head; wstrb = latched strobe; wlast = (w_cnt == len). Pop on wvalid&wready.
  - W may complete before AW; both are legal.
  - Exit to IDLE the cycle after both the AW handshake and the last W handshake have occurred.
  - A new instruction may be accepted in IDLE while earlier B responses are pending.

Outstanding counter and completion:
- outstd is decremented on bvalid&bready. A simultaneous accept and B leaves it unchanged.
- Completion: on bvalid&bready, pulse done with id=bid and err=(bresp!=00), registered with 1-cycle latency.
- A B arriving while outstd==0 is ignored. It is not counted below zero and no done is produced.

Decomposition:
- Package stb_pkg: FSM state encoding, AXI_BURST_INCR, AXI_RESP_OKAY, a clog2 helper for awsize, and the 4KB-check constant.
- Sub-module: stb_wdata_fifo, a synchronous FIFO with parameters DEPTH and WIDTH, plus full, empty and count outputs.

Test Plan:
- Single beat: len=0, addr 0x1000, ur_addr 5, strb 0xFFFF.
  - Expect one o_ur_re at address 5.
  - Expect awlen=0, awaddr=0x1000, one W with wlast=1.
  - After B OKAY id 3: done=1, id=3, err=0.
- 16-beat burst: len=15, wready toggling 1/0 every cycle, awready delayed 10 cycles.
  - Expect exactly 16 W beats with data matching UR rows ur_addr..ur_addr+15 in order, wlast on beat 16 only, and FIFO never overflowing.
- Outstanding limit: MAX_OUTSTD=4, bvalid held low, six back-to-back instructions.
  - Expect four accepted, then ready low.
  - After one B: ready rises and the fifth is accepted.
- Illegal instruction, both cases:
  - addr 0x0FF0 with len=1: crosses 4KB.
  - addr 0x1004: unaligned.
  - Each: no awvalid; done=1, err=1, id echoed.
- SLVERR: bresp=10 on the second of two outstanding bursts. Expect done err=0 then err=1, with IDs matching bid.
- Reset mid-burst: rst_n low during beat 7 of 16.
  - Expect all outputs 0 asynchronously, without waiting for a clock edge.
  - Expect o_state=0 and the next instruction to run cleanly.
